// File: rtl/multi_lane_hash_validator.sv
// Multi-lane final hash check: compares LANES SHA-256 results per beat against a
// compact-difficulty target over a fixed 3-cycle pipeline, reporting the first winner per block.
module multi_lane_hash_validator #(
  parameter int LANES   = 4,
  parameter int NONCE_W = 32,
  parameter int CNT_W   = 16
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       valid_i,
  input  logic                                       newblock_i,
  input  logic [256*LANES-1:0]                       hash_i,
  input  logic [NONCE_W-1:0]                         nonce_i,
  input  logic [31:0]                                difficulty_i,
  output logic                                       valid_o,
  output logic                                       newblock_o,
  output logic [LANES-1:0]                           success_o,
  output logic                                       found_valid_o,
  input  logic                                       found_ready_i,
  output logic [NONCE_W-1:0]                         found_nonce_o,
  output logic [((LANES > 1) ? $clog2(LANES) : 1)-1:0] found_lane_o,
  output logic [CNT_W-1:0]                           hit_count_o
);

  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int PW = $clog2(LANES + 1);

  function automatic logic [255:0] decode_target(input logic [31:0] diff);
    logic [255:0] mant;
    logic [7:0]   e;
    logic [10:0]  sh;
    mant = {232'd0, diff[7:0], diff[15:8], diff[23:16]};
    e    = diff[31:24];
    if (e >= 8'd3) begin
      sh = {3'b000, e - 8'd3} << 3;
      decode_target = mant << sh;
    end else begin
      sh = {3'b000, 8'd3 - e} << 3;
      decode_target = mant >> sh;
    end
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] base,
                                               input logic [PW-1:0]    inc);
    logic [CNT_W+PW:0] sum;
    sum = {{(PW+1){1'b0}}, base} + {{(CNT_W+1){1'b0}}, inc};
    if (sum > {{(PW+1){1'b0}}, {CNT_W{1'b1}}}) sat_add = '1;
    else                                       sat_add = sum[CNT_W-1:0];
  endfunction

  // Hash byte j becomes number byte 31-j so the compare is a plain unsigned <=.
  logic [255:0] num_in [LANES];
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      for (int i = 0; i < 32; i++) begin
        num_in[k][8*i +: 8] = hash_i[256*k + 8*(31-i) +: 8];
      end
    end
  end

  // ---- stage 1: capture numbers, nonce, control; decode target on newblock ----
  logic [255:0]       num_p0 [LANES];
  logic [NONCE_W-1:0] nonce_p0;
  logic               vld_p0, nb_p0;
  logic [255:0]       target_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0   <= 1'b0;
      nb_p0    <= 1'b0;
      nonce_p0 <= '0;
      target_q <= '0;
      for (int k = 0; k < LANES; k++) num_p0[k] <= '0;
    end else begin
      vld_p0   <= valid_i;
      nb_p0    <= valid_i && newblock_i;
      nonce_p0 <= nonce_i;
      num_p0   <= num_in;
      if (valid_i && newblock_i) target_q <= decode_target(difficulty_i);
    end
  end

  // ---- stage 2: per-lane compare against the block target ----
  logic [LANES-1:0]   pass_c;
  logic [LANES-1:0]   pass_p1;
  logic [NONCE_W-1:0] nonce_p1;
  logic               vld_p1, nb_p1;

  always_comb begin
    pass_c = '0;
    for (int k = 0; k < LANES; k++) pass_c[k] = vld_p0 && (num_p0[k] <= target_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pass_p1  <= '0;
      nonce_p1 <= '0;
      vld_p1   <= 1'b0;
      nb_p1    <= 1'b0;
    end else begin
      pass_p1  <= pass_c;
      nonce_p1 <= nonce_p0;
      vld_p1   <= vld_p0;
      nb_p1    <= nb_p0;
    end
  end

  // ---- stage 3: popcount, lowest-index winner, result register ----
  logic [PW-1:0]      pop_c;
  logic [LW-1:0]      win_lane_c;
  logic [NONCE_W-1:0] win_nonce_c;
  logic               any_c;
  logic               rep;

  always_comb begin
    pop_c      = '0;
    win_lane_c = '0;
    for (int k = LANES - 1; k >= 0; k--) begin
      pop_c = pop_c + PW'(pass_p1[k]);
      if (pass_p1[k]) win_lane_c = LW'(k);
    end
    any_c       = |pass_p1;
    win_nonce_c = nonce_p1 + NONCE_W'(win_lane_c);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_o       <= 1'b0;
      newblock_o    <= 1'b0;
      success_o     <= '0;
      hit_count_o   <= '0;
      found_valid_o <= 1'b0;
      found_nonce_o <= '0;
      found_lane_o  <= '0;
      rep           <= 1'b0;
    end else begin
      valid_o    <= vld_p1;
      newblock_o <= nb_p1;
      success_o  <= pass_p1;
      if (vld_p1) hit_count_o <= sat_add(nb_p1 ? '0 : hit_count_o, pop_c);
      // Later assignments take priority: accept, then newblock discard, then a fresh load.
      if (found_valid_o && found_ready_i) found_valid_o <= 1'b0;
      if (nb_p1) begin
        rep           <= 1'b0;
        found_valid_o <= 1'b0;
      end
      if (any_c && (!rep || nb_p1)) begin
        rep           <= 1'b1;
        found_valid_o <= 1'b1;
        found_nonce_o <= win_nonce_c;
        found_lane_o  <= win_lane_c;
      end
    end
  end

endmodule

// File: doc/multi_lane_hash_validator.md
Name: multi_lane_hash_validator

Overview:
- Parametrised successor to the single-lane final hash check.
- Compares LANES SHA-256 results per beat against a compact-difficulty target, pipelined over 3 cycles.
- Tracks the nonce of each lane, captures the first winning nonce per block behind a valid/ready result port, and counts hits per block.
- Sits after the final hash rounds and before the result reporting / host interface.

Parameters:
LANES, 4, hashes checked per beat (1..16)
NONCE_W, 32, nonce width
CNT_W, 16, width of the per-block hit counter (saturating)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
valid_i  in  1  beat valid; no backpressure, accepted every cycle
newblock_i  in  1  first beat of a new block; qualified by valid_i
hash_i  in  256*LANES  lane k occupies bits [256k+255:256k]
nonce_i  in  NONCE_W  nonce of lane 0; lane k nonce = nonce_i + k, modulo 2^NONCE_W
difficulty_i  in  32  compact difficulty; sampled only on valid_i && newblock_i
valid_o  out  1  valid_i delayed 3 cycles
newblock_o  out  1  (valid_i && newblock_i) delayed 3 cycles
success_o  out  LANES  per-lane pass flags, aligned with valid_o; 0 when valid_o=0
found_valid_o  out  1  result held
found_ready_i  in  1  consumer accepts result
found_nonce_o  out  NONCE_W  winning nonce
found_lane_o  out  $clog2(LANES) or 1  winning lane index
hit_count_o  out  CNT_W  passing lanes seen in the current block; saturates at all-ones

Behaviour:
- Clock is clk. Reset is synchronous and active-high on rst.
- While rst=1 at a rising edge: every output, pipeline register, target_q and the result register clear to 0.
- Hash numeric form: number byte i = hash byte (31-i), where hash byte j = bits [8j+7:8j]. So number[7:0] = hash[255:248].
- Mantissa: mantissa[7:0] = difficulty_i[23:16], mantissa[15:8] = difficulty_i[15:8], mantissa[23:16] = difficulty_i[7:0].
- Exponent: exp = difficulty_i[31:24], unsigned.
- Target for exp >= 3: mantissa << 8*(exp-3). The shift is 256-bit; bits above bit 255 are discarded, so exp >= 35 gives target 0.
- Target for exp < 3: mantissa >> 8*(3-exp).
- Stage 1 (edge after input):
  - Register the byte-reversed hashes, the lane-0 nonce, valid and newblock.
  - On valid_i && newblock_i, target_q loads the decoded target at this same edge, so the newblock beat is judged against its own difficulty.
  - Otherwise target_q holds its value.
- Stage 2: per-lane unsigned compare pass[k] = (number_k <= target_q). Passes are masked by valid.
- Stage 3:
  - Drive valid_o, newblock_o and success_o.
  - Select the winner by priority: the lowest-index passing lane.
  - Total latency from input to outputs is 3 cycles, fixed.
- hit_count_o, updated at stage 3:
  - On a newblock beat it loads popcount(pass).
  - Otherwise it adds popcount(pass), saturating at all-ones.
- Result register, one entry, with per-block "reported" flag rep:
  - A stage-3 beat with any pass and rep=0 loads found_nonce_o/found_lane_o, sets found_valid_o=1 and sets rep=1.
  - A beat arriving while rep=1 is counted in hit_count_o but not reported.
  - Accept: found_valid_o && found_ready_i clears found_valid_o at the next edge. The data registers hold their values.
  - Newblock beat at stage 3: rep is cleared and any pending unaccepted result is discarded.
  - If that newblock beat itself passes, it loads a new result in the same cycle; the new result wins over discard and over an accept in that cycle.
- Nonce arithmetic for lanes wraps modulo 2^NONCE_W (e.g. nonce_i=0xFFFFFFFF, lane 1 -> 0x00000000).
- valid_i=0 beats do not propagate passes and do not change target_q, hit_count_o or the result register.
- Reset mid-stream flushes the pipeline. The first post-reset block must carry newblock_i. Beats before it are judged against target 0.

Test Plan:
- Exact-boundary pass:
  - Stimulus: rst, then newblock beat with difficulty_i=0x03563412 (target 0x123456), lane 0 hash[255:232]=0x563412, rest 0, nonce_i=100.
  - Response: 3 cycles later success_o[0]=1, found_nonce_o=100, found_lane_o=0, hit_count_o=1.
- Just-over fail: same beat but hash[255:232]=0x573412 (number 0x123457) -> success_o[0]=0, found_valid_o stays 0.
- Priority and counting:
  - Stimulus: LANES=4, lanes 1 and 3 pass, nonce_i=0xFFFFFFFF.
  - Response: found_lane_o=1, found_nonce_o=0x00000000, hit_count_o=2.
- Second win is not reported:
  - Stimulus: hold found_ready_i=0, then a later beat in the same block passes.
  - Response: found_nonce_o unchanged and hit_count_o increments; after found_ready_i=1 for 1 cycle, found_valid_o=0.
- Newblock flushes the pending result:
  - Stimulus: result pending, then a newblock beat with difficulty_i=0x23000000 (exp 35, target 0) and all hashes nonzero.
  - Response: found_valid_o=0, hit_count_o=0. Then a second newblock with difficulty_i=0x04000001 (target 0x01000000) and a passing lane 2 -> result loads lane 2.
- Mid-stream reset: rst=1 for 1 cycle while passing beats are in flight -> valid_o, success_o, found_valid_o and hit_count_o are all 0 on the following 3 cycles.
